// File: rtl/seg_scan_if.sv
// Load/display bundle between the score logic and the 7-segment scan driver.
interface seg_scan_if #(
  parameter int unsigned DIGITS = 4
);
  logic                  load;
  logic [4*DIGITS-1:0]   digits_in;
  logic [DIGITS-1:0]     dp_in;
  logic [DIGITS-1:0]     blank_in;
  logic                  glyph_mode;
  logic                  lz_suppress;
  logic [3:0]            brightness;
  logic [6:0]            seg;
  logic                  dp;
  logic [DIGITS-1:0]     an;
  logic                  frame_tick;

  modport master (
    output load, digits_in, dp_in, blank_in, glyph_mode, lz_suppress, brightness,
    input  seg, dp, an, frame_tick
  );

  modport slave (
    input  load, digits_in, dp_in, blank_in, glyph_mode, lz_suppress, brightness,
    output seg, dp, an, frame_tick
  );
endinterface

// File: rtl/seg_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver with hex/cricket glyphs,
// PWM brightness, blanking, decimal points and leading-zero suppression.
module seg_scan_driver #(
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned REFRESH_DIV = 100000,
  parameter bit          ACTIVE_LOW  = 1'b1
) (
  input  logic      clk,
  input  logic      rst_n,
  seg_scan_if.slave bus
);

  localparam int unsigned PW = $clog2(REFRESH_DIV);
  localparam int unsigned IW = $clog2(DIGITS);
  localparam int unsigned DW = 4 * DIGITS;
  localparam logic [PW-1:0] PTERM = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] ILAST = IW'(DIGITS - 1);
  localparam logic          INV   = ~ACTIVE_LOW;

  logic [PW-1:0]     presc_q, presc_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [3:0]        pwm_q, pwm_d;
  logic [DW-1:0]     digits_q, digits_d;
  logic [DIGITS-1:0] dpv_q, dpv_d;
  logic [DIGITS-1:0] blank_q, blank_d;
  logic              wrap;

  logic [6:0]        seg_q, seg_n;
  logic              dp_q, dp_n;
  logic [DIGITS-1:0] an_q, an_n;
  logic              tick_q;

  logic [DIGITS-1:0] supp;
  logic              lead;
  logic [3:0]        nib;
  logic              dark;
  logic              lit;
  logic [6:0]        seg_lo;
  logic              dp_lo;
  logic [DIGITS-1:0] an_lo;

  // Glyph lookup in active-low polarity; cricket set overrides codes 12..15.
  function automatic logic [6:0] decode(input logic [3:0] code, input logic cricket);
    logic [6:0] g;
    case (code)
      4'h0: g = 7'b1000000;
      4'h1: g = 7'b1111001;
      4'h2: g = 7'b0100100;
      4'h3: g = 7'b0110000;
      4'h4: g = 7'b0011001;
      4'h5: g = 7'b0010010;
      4'h6: g = 7'b0000010;
      4'h7: g = 7'b1111000;
      4'h8: g = 7'b0000000;
      4'h9: g = 7'b0010000;
      4'hA: g = 7'b0001000;
      4'hB: g = 7'b0000011;
      4'hC: g = cricket ? 7'b1011111 : 7'b1000110;
      4'hD: g = cricket ? 7'b1001111 : 7'b0100001;
      4'hE: g = cricket ? 7'b1111101 : 7'b0000110;
      default: g = cricket ? 7'b0000111 : 7'b0001110;
    endcase
    return g;
  endfunction

  // Scan counters and shadow capture.
  always_comb begin
    presc_d  = presc_q + PW'(1);
    idx_d    = idx_q;
    wrap     = 1'b0;
    pwm_d    = pwm_q + 4'd1;
    digits_d = digits_q;
    dpv_d    = dpv_q;
    blank_d  = blank_q;
    if (presc_q == PTERM) begin
      presc_d = '0;
      if (idx_q == ILAST) begin
        idx_d = '0;
        wrap  = 1'b1;
      end else begin
        idx_d = idx_q + IW'(1);
      end
    end
    if (bus.load) begin
      digits_d = bus.digits_in;
      dpv_d    = bus.dp_in;
      blank_d  = bus.blank_in;
    end
  end

  // A zero digit stays suppressed while everything above it is zero or blanked.
  always_comb begin
    supp = '0;
    lead = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      if (bus.lz_suppress && lead && (digits_q[4*i +: 4] == 4'h0)) supp[i] = 1'b1;
      lead = lead & ((digits_q[4*i +: 4] == 4'h0) | blank_q[i]);
    end
  end

  // Output image for the cycle after this edge, built from the upcoming scan position.
  always_comb begin
    nib    = digits_q[{idx_d, 2'b00} +: 4];
    dark   = blank_q[idx_d] | supp[idx_d];
    seg_lo = dark ? 7'h7F : decode(nib, bus.glyph_mode);
    dp_lo  = dark | ~dpv_q[idx_d];
    lit    = (presc_d != '0) && ((bus.brightness == 4'hF) || (pwm_d < bus.brightness));
    an_lo  = lit ? ~(DIGITS'(1) << idx_d) : '1;
    seg_n  = seg_lo ^ {7{INV}};
    dp_n   = dp_lo ^ INV;
    an_n   = an_lo ^ {DIGITS{INV}};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q  <= '0;
      idx_q    <= '0;
      pwm_q    <= '0;
      digits_q <= '0;
      dpv_q    <= '0;
      blank_q  <= '1;
      seg_q    <= 7'h7F ^ {7{INV}};
      dp_q     <= 1'b1 ^ INV;
      an_q     <= {DIGITS{~INV}};
      tick_q   <= 1'b0;
    end else begin
      presc_q  <= presc_d;
      idx_q    <= idx_d;
      pwm_q    <= pwm_d;
      digits_q <= digits_d;
      dpv_q    <= dpv_d;
      blank_q  <= blank_d;
      seg_q    <= seg_n;
      dp_q     <= dp_n;
      an_q     <= an_n;
      tick_q   <= wrap;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.an         = an_q;
  assign bus.frame_tick = tick_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: timeline model of scan position plus shadow
// contents, checked every cycle, with hand-computed literal checks per scenario.
module tb_seg_scan_driver;

  localparam int D = 4;
  localparam int R = 8;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  seg_scan_if #(.DIGITS(D)) bus ();

  seg_scan_driver #(.DIGITS(D), .REFRESH_DIV(R), .ACTIVE_LOW(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] hex_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
  logic [6:0] cri_tab [4]  = '{7'b1011111, 7'b1001111, 7'b1111101, 7'b0000111};

  // Model: t counts edges since reset release; slot position follows from t.
  int         t;
  bit         started;
  logic [15:0] m_dig;
  logic [3:0]  m_dp;
  logic [3:0]  m_blank;
  logic [6:0]  exp_seg;
  logic        exp_dp;
  logic [3:0]  exp_an;
  logic        exp_ft;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s t=%0d got=%h want=%h", nm, t, act, want);
    end
  endtask

  always @(posedge clk) begin
    int d;
    int ph;
    logic [3:0] nib;
    logic sup;
    started = 1'b1;
    if (!rst_n) begin
      t = 0;
      m_dig = '0;
      m_dp = '0;
      m_blank = '1;
      exp_seg = 7'h7F;
      exp_dp = 1'b1;
      exp_an = 4'hF;
      exp_ft = 1'b0;
    end else begin
      t++;
      ph = t % R;
      d = (t / R) % D;
      nib = m_dig[4*d +: 4];
      sup = 1'b0;
      if (bus.lz_suppress && d > 0 && nib == 4'h0) begin
        sup = 1'b1;
        for (int j = d + 1; j < D; j++)
          if (m_dig[4*j +: 4] != 4'h0 && !m_blank[j]) sup = 1'b0;
      end
      if (m_blank[d] || sup) begin
        exp_seg = 7'h7F;
        exp_dp = 1'b1;
      end else begin
        exp_seg = (bus.glyph_mode && nib >= 4'd12) ? cri_tab[nib - 4'd12] : hex_tab[nib];
        exp_dp = ~m_dp[d];
      end
      exp_an = (ph != 0 && (bus.brightness == 4'hF || (t % 16) < int'(bus.brightness)))
               ? ~(4'b0001 << d) : 4'hF;
      exp_ft = (ph == 0 && d == 0);
      if (bus.load) begin
        m_dig = bus.digits_in;
        m_dp = bus.dp_in;
        m_blank = bus.blank_in;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("seg", 32'(bus.seg), 32'(exp_seg));
      chk("dp", 32'(bus.dp), 32'(exp_dp));
      chk("an", 32'(bus.an), 32'(exp_an));
      chk("frame_tick", 32'(bus.frame_tick), 32'(exp_ft));
    end
  end

  task automatic do_load(input logic [15:0] dg, input logic [3:0] dpv, input logic [3:0] bl);
    bus.digits_in = dg;
    bus.dp_in = dpv;
    bus.blank_in = bl;
    bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
  endtask

  // Park on the third cycle of the given digit's slot (past the guard cycle).
  task automatic wait_slot(input int dig);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!((t % R) == 2 && ((t / R) % D) == dig) && n < 200);
    if (n >= 200) begin
      total++;
      bad++;
      $display("FAIL slot_wait digit=%0d got=timeout want=reached", dig);
    end
  endtask

  task automatic slot_lit(input string nm, input int dig, input logic [3:0] an_w,
                          input logic [6:0] seg_w);
    wait_slot(dig);
    chk({nm, "_an"}, 32'(bus.an), 32'(an_w));
    chk({nm, "_seg"}, 32'(bus.seg), 32'(seg_w));
  endtask

  task automatic frame_wait(output int n, output int lit_segs);
    n = 0;
    lit_segs = 0;
    do begin
      @(negedge clk);
      n++;
      if (bus.seg != 7'h7F) lit_segs++;
    end while (!bus.frame_tick && n < 100);
  endtask

  task automatic count_active(output int act);
    act = 0;
    repeat (32) begin
      @(negedge clk);
      if (bus.an != 4'hF) act++;
    end
  endtask

  initial begin
    int n;
    int lit_segs;
    int act;
    total = 0;
    bad = 0;
    t = 0;
    started = 1'b0;
    rst_n = 1'b0;
    bus.load = 1'b0;
    bus.digits_in = '0;
    bus.dp_in = '0;
    bus.blank_in = '0;
    bus.glyph_mode = 1'b0;
    bus.lz_suppress = 1'b0;
    bus.brightness = 4'd0;

    // Reset darkness and first frame tick
    repeat (3) @(negedge clk);
    chk("rst_seg", 32'(bus.seg), 32'h7F);
    chk("rst_an", 32'(bus.an), 32'hF);
    chk("rst_dp", 32'(bus.dp), 32'h1);
    chk("rst_tick", 32'(bus.frame_tick), 32'h0);
    rst_n = 1'b1;
    frame_wait(n, lit_segs);
    chk("first_tick_cycles", 32'(n), 32'd32);
    chk("dark_before_load", 32'(lit_segs), 32'd0);

    // Hex scan
    bus.brightness = 4'd15;
    do_load(16'h1A2F, 4'h0, 4'h0);
    slot_lit("hex_d0", 0, 4'b1110, 7'b0001110);
    slot_lit("hex_d1", 1, 4'b1101, 7'b0100100);
    slot_lit("hex_d2", 2, 4'b1011, 7'b0001000);
    slot_lit("hex_d3", 3, 4'b0111, 7'b1111001);

    // Cricket glyphs
    bus.glyph_mode = 1'b1;
    do_load(16'hFC1D, 4'h0, 4'h0);
    slot_lit("cri_d0", 0, 4'b1110, 7'b1001111);
    slot_lit("cri_d1", 1, 4'b1101, 7'b1111001);
    slot_lit("cri_d2", 2, 4'b1011, 7'b1011111);
    slot_lit("cri_d3", 3, 4'b0111, 7'b0000111);

    // Leading-zero suppression
    bus.glyph_mode = 1'b0;
    bus.lz_suppress = 1'b1;
    do_load(16'h0070, 4'h0, 4'h0);
    slot_lit("lz_d3", 3, 4'b0111, 7'h7F);
    slot_lit("lz_d2", 2, 4'b1011, 7'h7F);
    slot_lit("lz_d1", 1, 4'b1101, 7'b1111000);
    slot_lit("lz_d0", 0, 4'b1110, 7'b1000000);
    do_load(16'h0000, 4'h0, 4'h0);
    slot_lit("lz0_d1", 1, 4'b1101, 7'h7F);
    slot_lit("lz0_d0", 0, 4'b1110, 7'b1000000);

    // PWM duty
    bus.lz_suppress = 1'b0;
    do_load(16'h1A2F, 4'h0, 4'h0);
    bus.brightness = 4'd4;
    count_active(act);
    chk("pwm4_active", 32'(act), 32'd6);
    bus.brightness = 4'd0;
    count_active(act);
    chk("pwm0_active", 32'(act), 32'd0);

    // Blanking overrides dp
    bus.brightness = 4'd15;
    do_load(16'h1234, 4'b0110, 4'b0100);
    wait_slot(2);
    chk("blank_d2_seg", 32'(bus.seg), 32'h7F);
    chk("blank_d2_dp", 32'(bus.dp), 32'h1);
    wait_slot(1);
    chk("dp_d1_seg", 32'(bus.seg), 32'(7'b0110000));
    chk("dp_d1_dp", 32'(bus.dp), 32'h0);

    // Mid-scan reset with a colliding load
    wait_slot(2);
    rst_n = 1'b0;
    bus.digits_in = 16'h8888;
    bus.dp_in = 4'hF;
    bus.blank_in = 4'h0;
    bus.load = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    bus.load = 1'b0;
    chk("mrst_seg", 32'(bus.seg), 32'h7F);
    chk("mrst_an", 32'(bus.an), 32'hF);
    chk("mrst_dp", 32'(bus.dp), 32'h1);
    frame_wait(n, lit_segs);
    chk("mrst_tick_cycles", 32'(n), 32'd32);
    chk("mrst_dark", 32'(lit_segs), 32'd0);
    do_load(16'h0005, 4'h0, 4'h0);
    slot_lit("post_d0", 0, 4'b1110, 7'b0010010);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Time-multiplexed driver for a DIGITS-wide common-anode 7-segment display bank. It latches a packed nibble vector through a load strobe and scans one digit per refresh slot. Each nibble is decoded through a selectable glyph table: standard hex, or the cricket scoreboard set `'`, `I`, `'`, `t` for codes 12–15. It also adds PWM brightness, per-digit blanking, decimal points and leading-zero suppression. It sits between the scoreboard/score logic and the board's `seg`/`an`/`dp` pins.

## Interface
- `DIGITS`, default 4: number of digits scanned, 2..8.
- `REFRESH_DIV`, default 100000: clock cycles per digit slot, at least 4.
- `ACTIVE_LOW`, default 1: 1 means segments, dp and anodes are driven low-true; 0 inverts all three.
- `clk` (input, 1 bit): single system clock; everything is rising-edge.
- `rst_n` (input, 1 bit): reset, synchronous and active-low.
- `load` (input, 1 bit): one-cycle strobe that captures `digits_in`, `dp_in`, `blank_in` into shadow registers.
- `digits_in` (input, 4*DIGITS bits): nibble i sits at [4i+3:4i]; digit 0 is the rightmost.
- `dp_in` (input, DIGITS bits): decimal point per digit, 1 = lit.
- `blank_in` (input, DIGITS bits): 1 = digit forced dark.
- `glyph_mode` (input, 1 bit): 0 = hex table, 1 = cricket table.
- `lz_suppress` (input, 1 bit): 1 = blank leading zeros.
- `brightness` (input, 4 bits): PWM duty; 0 = off, 15 = full.
- `seg` (output, 7 bits): segments, bit order gfedcba, bit 6 = g.
- `dp` (output, 1 bit): decimal point.
- `an` (output, DIGITS bits): anode enables, one-hot when active.
- `frame_tick` (output, 1 bit): one-cycle pulse each time the scan wraps from digit DIGITS-1 to 0.

## Operation
- **Shadow registers**
  - On `load`, all three vectors are captured.
  - Reset clears the digits and dp to 0 and sets blank to all-ones, so the display is dark until the first load.
  - `glyph_mode`, `lz_suppress` and `brightness` are sampled live every cycle.
- **Scan**
  - The prescaler counts 0..REFRESH_DIV-1 and wraps.
  - At the terminal count the digit index advances and wraps DIGITS-1 to 0.
  - `frame_tick` pulses on the index wrap.
- **Hex table**, values in active-low polarity:
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000
  - 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000
  - 8 = 0000000, 9 = 0010000, A = 0001000, b = 0000011
  - C = 1000110, d = 0100001, E = 0000110, F = 0001110
- **Cricket table**
  - Codes 0–11 are identical to the hex table.
  - 12 = 1011111 (left apostrophe), 13 = 1001111 (I), 14 = 1111101 (right apostrophe), 15 = 0000111 (t).
- **Leading-zero suppression**
  - Digit i is suppressed when `lz_suppress`=1, its nibble is 0, and every digit above i is either 0 or blanked.
  - Digit 0 is never suppressed.
- **Dark digits**
  - A blanked or suppressed digit shows all segments off and dp off.
  - Its anode still follows the scan.
- **PWM**
  - A free-running 4-bit counter increments every cycle.
  - The anode is enabled when `brightness`==15, or when the counter is less than `brightness`.
  - `brightness`=0 keeps all anodes inactive; `seg` still decodes.
- **Ghost guard**: `an` is all-inactive for the first cycle of every slot.
- **Polarity**: with `ACTIVE_LOW`=0, `seg`, `dp` and `an` are bitwise inverted.

## Timing
- **Outputs**: all registered; no combinational path from any input to any output.
- **Reset values** (`ACTIVE_LOW`=1):
  - `seg`=7'h7F, `dp`=1, `an`=all-ones, `frame_tick`=0.
  - Prescaler, index and PWM counter are 0.
- **Load latency**
  - `load` sampled at edge k updates the shadow registers at k.
  - The outputs reflect the new data at edge k+1, within the current slot.
  - `load` during the ghost-guard cycle is captured normally.
- **Slot boundary**
  - The index changes at the prescaler terminal count.
  - `an` is all-inactive in the next cycle, then the new digit's anode is active (subject to PWM) for the remaining REFRESH_DIV-1 cycles.
  - `seg` and `dp` switch to the new digit in the same cycle as the guard.
- **frame_tick**: asserted in the same cycle the index becomes 0.
- **Live input changes**: a change to `glyph_mode`, `lz_suppress` or `brightness` takes effect on the next cycle's outputs.
- **Reset mid-scan**
  - `rst_n` low at any edge returns every register to its reset value at that edge.
  - After release the scan restarts at digit 0, prescaler 0.

## Test plan
- **Reset darkness**: `DIGITS`=4, `REFRESH_DIV`=8. Hold `rst_n`=0 for 3 cycles, then release with no load -> `seg`=7'h7F, `an`=4'hF, `dp`=1 throughout. First `frame_tick` arrives 32 cycles after release.
- **Scan and decode**: load `digits_in`=16'h1A2F, `glyph_mode`=0, `brightness`=15 -> in each slot, after the one-cycle guard, the active digit shows:
  - digit 0: `an`=1110, `seg`=0001110 (F)
  - digit 1: `an`=1101, `seg`=0100100 (2)
  - digit 2: `an`=1011, `seg`=0001000 (A)
  - digit 3: `an`=0111, `seg`=1111001 (1)
- **Cricket glyphs**: load 16'hFC1D with `glyph_mode`=1 -> slots show 1001111 (I), 1111001 (1), 1011111 (left apostrophe), 0000111 (t).
- **Leading-zero suppression**: load 16'h0070 with `lz_suppress`=1 -> digits 3 and 2 show 7'h7F, digit 1 shows 7, digit 0 shows 0. Load 16'h0000 -> only digit 0 is lit, showing 0.
- **PWM and blanking**: `brightness`=4 -> each digit's anode is active for 4 of every 16 cycles. `brightness`=0 -> `an` stays 4'hF. `blank_in`=4'b0100 -> digit 2 shows 7'h7F with `dp`=1 despite `dp_in`[2]=1.
- **Mid-operation reset**: assert `rst_n`=0 for 1 cycle during digit 2's slot, with a load pending at the same edge -> the outputs return to reset values and the load is discarded. The scan resumes at digit 0 and the display stays dark until the next `load`.
